// File: rtl/axi4_burst_csr_slave.sv
// AXI4 full slave: word-addressed buffer with a CSR window in words 0..3 and a
// start/busy/done/error handshake towards the accelerator master.
module axi4_burst_csr_slave #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 12,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 128,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_MEM_DEPTH        = 256
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     input_Addr_Offset,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     output_Addr_Offset,
  output logic                              INIT_AXI_TXN,
  input  logic                              TXN_DONE,
  input  logic                              ERROR
);

  localparam int unsigned Lsb   = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int unsigned IdxW  = $clog2(C_MEM_DEPTH);
  localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;

  typedef logic [IdxW-1:0]               idx_t;
  typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

  function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst,
                                    input logic [7:0] len);
    idx_t mask;
    idx_t inc;
    mask = idx_t'(len);
    inc  = idx + idx_t'(1);
    unique case (burst)
      2'b00:   return idx;
      2'b10:   return (idx & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  function automatic logic burst_err(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_bad;
    wrap_bad = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || wrap_bad || (size != 3'(Lsb)) ||
           (|addr[C_S_AXI_ADDR_WIDTH-1:Lsb+IdxW]);
  endfunction

  function automatic word_t merge(input word_t old, input word_t nw,
                                  input logic [StrbW-1:0] strb);
    word_t r;
    r = old;
    for (int b = 0; b < StrbW; b++) begin
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  // Ready outputs stay low until the first clock after reset release.
  logic alive_q;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) alive_q <= 1'b0;
    else                alive_q <= 1'b1;
  end

  // ---------------------------------------------------------------- write path
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  w_state_e                    w_state_q, w_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] awid_q, awid_d;
  idx_t                        widx_q, widx_d;
  logic [7:0]                  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]                  wburst_q, wburst_d;
  logic                        werr_q, werr_d;
  logic                        aw_hs, w_beat, w_last_beat, wlast_bad, w_commit;
  logic                        csr_sel, csr_we, mem_we;

  assign S_AXI_AWREADY = (w_state_q == WIdle) && alive_q;
  assign S_AXI_WREADY  = (w_state_q == WData);
  assign S_AXI_BVALID  = (w_state_q == WResp);
  assign S_AXI_BID     = awid_q;
  assign S_AXI_BRESP   = (S_AXI_BVALID && werr_q) ? 2'b10 : 2'b00;

  assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_beat      = (w_state_q == WData) && S_AXI_WVALID;
  assign w_last_beat = (wcnt_q == wlen_q);
  assign wlast_bad   = (S_AXI_WLAST != w_last_beat);
  // Error is sticky, so a WLAST mismatch suppresses its own beat and all later ones.
  assign w_commit    = w_beat && !werr_q && !wlast_bad;
  assign csr_sel     = (widx_q[IdxW-1:2] == '0);
  assign csr_we      = w_commit && csr_sel;
  assign mem_we      = w_commit && !csr_sel;

  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wburst_d  = wburst_q;
    werr_d    = werr_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          awid_d    = S_AXI_AWID;
          widx_d    = S_AXI_AWADDR[Lsb +: IdxW];
          wlen_d    = S_AXI_AWLEN;
          wburst_d  = S_AXI_AWBURST;
          wcnt_d    = '0;
          werr_d    = burst_err(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
          w_state_d = WData;
        end
      end
      WData: begin
        if (w_beat) begin
          widx_d = next_idx(widx_q, wburst_q, wlen_q);
          wcnt_d = wcnt_q + 8'd1;
          werr_d = werr_q | wlast_bad;
          if (w_last_beat) w_state_d = WResp;
        end
      end
      WResp: begin
        if (S_AXI_BREADY) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= WIdle;
      awid_q    <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
    end
  end

  word_t mem [C_MEM_DEPTH];

  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (S_AXI_WSTRB[b]) mem[widx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------- CSR
  word_t csr0_q, csr0_d, csr1_q, csr1_d;
  logic  busy_q, busy_d, done_q, done_d, error_q, error_d, init_q, init_d;
  logic  start_req;
  word_t status;

  assign status    = word_t'({error_q, done_q, busy_q});
  assign start_req = csr_we && (widx_q[1:0] == 2'd2) && S_AXI_WSTRB[0] &&
                     S_AXI_WDATA[0] && !busy_q;

  assign input_Addr_Offset  = csr0_q[C_S_AXI_ADDR_WIDTH-1:0];
  assign output_Addr_Offset = csr1_q[C_S_AXI_ADDR_WIDTH-1:0];
  assign INIT_AXI_TXN       = init_q;

  always_comb begin
    csr0_d  = csr0_q;
    csr1_d  = csr1_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    init_d  = 1'b0;
    if (csr_we && widx_q[1:0] == 2'd0) csr0_d = merge(csr0_q, S_AXI_WDATA, S_AXI_WSTRB);
    if (csr_we && widx_q[1:0] == 2'd1) csr1_d = merge(csr1_q, S_AXI_WDATA, S_AXI_WSTRB);
    if (ERROR && busy_q) error_d = 1'b1;
    // Completion takes priority over a coincident START, which is dropped.
    if (TXN_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else if (start_req) begin
      init_d  = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      csr0_q  <= '0;
      csr1_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      csr0_q  <= csr0_d;
      csr1_q  <= csr1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      init_q  <= init_d;
    end
  end

  // ----------------------------------------------------------------- read path
  typedef enum logic {RIdle, RData} r_state_e;
  r_state_e                    r_state_q, r_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  idx_t                        ridx_q, ridx_d, ar_idx, r_nidx, rd_idx;
  logic [7:0]                  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]                  rburst_q, rburst_d;
  logic                        rerr_q, rerr_d, rlast_q, rlast_d, ar_hs, ar_err;
  word_t                       rdata_q, rdata_d, rd_word;

  assign S_AXI_ARREADY = (r_state_q == RIdle) && alive_q;
  assign S_AXI_RVALID  = (r_state_q == RData);
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = (S_AXI_RVALID && rerr_q) ? 2'b10 : 2'b00;

  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_idx = S_AXI_ARADDR[Lsb +: IdxW];
  assign ar_err = burst_err(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
  assign r_nidx = next_idx(ridx_q, rburst_q, rlen_q);
  assign rd_idx = (r_state_q == RIdle) ? ar_idx : r_nidx;

  // Data is captured into rdata_q at the edge, so a same-cycle write returns old data.
  always_comb begin
    rd_word = mem[rd_idx];
    if (rd_idx[IdxW-1:2] == '0) begin
      unique case (rd_idx[1:0])
        2'd0:    rd_word = csr0_q;
        2'd1:    rd_word = csr1_q;
        2'd2:    rd_word = '0;
        default: rd_word = status;
      endcase
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rburst_d  = rburst_q;
    rerr_d    = rerr_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          rid_d     = S_AXI_ARID;
          ridx_d    = ar_idx;
          rlen_d    = S_AXI_ARLEN;
          rburst_d  = S_AXI_ARBURST;
          rerr_d    = ar_err;
          rcnt_d    = '0;
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          rdata_d   = ar_err ? '0 : rd_word;
          r_state_d = RData;
        end
      end
      default: begin
        if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = RIdle;
          end else begin
            ridx_d  = r_nidx;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            rdata_d = rerr_q ? '0 : rd_word;
          end
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= RIdle;
      rid_q     <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rburst_q  <= '0;
      rerr_q    <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rburst_q  <= rburst_d;
      rerr_q    <= rerr_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4_burst_csr_slave.sv
// Directed plus randomized bench for axi4_burst_csr_slave, checked against a
// word-array reference model built from the burst addressing rules.
module tb_axi4_burst_csr_slave;
  localparam int IDW = 12, DW = 128, AW = 64, DEPTH = 256;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [IDW-1:0] S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
  logic [AW-1:0]  S_AXI_AWADDR, S_AXI_ARADDR, input_Addr_Offset, output_Addr_Offset;
  logic [7:0]     S_AXI_AWLEN, S_AXI_ARLEN;
  logic [2:0]     S_AXI_AWSIZE, S_AXI_ARSIZE;
  logic [1:0]     S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic           S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic           S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic           S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  logic [DW-1:0]  S_AXI_WDATA, S_AXI_RDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic           INIT_AXI_TXN, TXN_DONE, ERROR;

  always #5 clk = ~clk;

  axi4_burst_csr_slave #(
    .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW), .C_MEM_DEPTH(DEPTH)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .input_Addr_Offset(input_Addr_Offset), .output_Addr_Offset(output_Addr_Offset),
    .INIT_AXI_TXN(INIT_AXI_TXN), .TXN_DONE(TXN_DONE), .ERROR(ERROR)
  );

  logic [DW-1:0]   model [DEPTH];
  logic [DW-1:0]   wdq[$];
  logic [DW/8-1:0] wsq[$];
  logic [DW-1:0]   rdq[$];
  logic [1:0]      rrq[$];
  logic            rlq[$];
  int n_pass = 0, n_total = 0, init_cnt = 0;

  always @(negedge clk) if (INIT_AXI_TXN === 1'b1) init_cnt++;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Word visited on beat i of a burst, from the AXI burst rules.
  function automatic int beat_idx(input int start, input int len, input logic [1:0] bt,
                                  input int i);
    int n;
    n = len + 1;
    if (bt == 2'b00) return start;
    if (bt == 2'b10) return (start / n) * n + ((start % n) + i) % n;
    return (start + i) % DEPTH;
  endfunction

  task automatic model_write(input int start, input int len, input logic [1:0] bt);
    int idx;
    for (int i = 0; i <= len; i++) begin
      idx = beat_idx(start, len, bt, i);
      for (int b = 0; b < DW / 8; b++)
        if (wsq[i][b]) model[idx][8*b +: 8] = wdq[i][8*b +: 8];
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [1:0] bt,
                           input logic [2:0] size, input int wlast_beat, input bit hold_b,
                           output logic [1:0] resp);
    int t;
    logic [IDW-1:0] id;
    id = IDW'($urandom);
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len);
    S_AXI_AWSIZE = size; S_AXI_AWBURST = bt; S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!S_AXI_AWREADY && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) check("aw_timeout", 0, 1);
    @(posedge clk); #1; S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      S_AXI_WDATA = wdq[i]; S_AXI_WSTRB = wsq[i];
      S_AXI_WLAST = (i == wlast_beat); S_AXI_WVALID = 1'b1;
      t = 0;
      while (!S_AXI_WREADY && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) check("w_timeout", 0, 1);
      @(posedge clk); #1; S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    end
    resp = 2'bxx;
    if (!hold_b) begin
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
      S_AXI_BREADY = 1'b1;
      t = 0;
      while (!S_AXI_BVALID && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) check("b_timeout", 0, 1);
      resp = S_AXI_BRESP;
      check("bid", DW'(S_AXI_BID), DW'(id));
      @(posedge clk); #1; S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [1:0] bt,
                          input logic [2:0] size);
    int t, got;
    logic [IDW-1:0] id;
    rdq.delete(); rrq.delete(); rlq.delete();
    id = IDW'($urandom);
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len);
    S_AXI_ARSIZE = size; S_AXI_ARBURST = bt; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!S_AXI_ARREADY && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) check("ar_timeout", 0, 1);
    @(posedge clk); #1; S_AXI_ARVALID = 1'b0;
    got = 0; t = 0;
    while (got <= len && t < 3000) begin
      S_AXI_RREADY = ($urandom_range(0, 3) != 0);
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        rdq.push_back(S_AXI_RDATA); rrq.push_back(S_AXI_RRESP); rlq.push_back(S_AXI_RLAST);
        check("rid", DW'(S_AXI_RID), DW'(id));
        got++;
      end
      @(posedge clk); #1; t++;
    end
    S_AXI_RREADY = 1'b0;
    if (got <= len) check("r_timeout", 0, 1);
  endtask

  task automatic wr1(input logic [AW-1:0] addr, input logic [DW-1:0] d, output logic [1:0] resp);
    wdq.delete(); wsq.delete();
    wdq.push_back(d); wsq.push_back('1);
    axi_write(addr, 0, 2'b01, 3'd4, 0, 1'b0, resp);
  endtask

  task automatic pulse(input bit is_done);
    if (is_done) TXN_DONE = 1'b1; else ERROR = 1'b1;
    @(posedge clk); #1; TXN_DONE = 1'b0; ERROR = 1'b0;
  endtask

  logic [1:0] resp;
  int kind, len, start;
  logic [1:0] bt;

  initial begin
    rst_n = 1'b0;
    {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_WLAST, S_AXI_BREADY} = '0;
    {S_AXI_ARVALID, S_AXI_RREADY, TXN_DONE, ERROR} = '0;
    {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST} = '0;
    {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST} = '0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_rlast", S_AXI_RLAST, 0);
    check("rst_bresp", S_AXI_BRESP, 0);
    check("rst_init", INIT_AXI_TXN, 0);
    check("rst_in_off", input_Addr_Offset, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("awready_idle", S_AXI_AWREADY, 1);

    // Clear buffer words 4..255 so every later read has a defined expectation.
    wdq.delete(); wsq.delete();
    for (int i = 0; i < DEPTH - 4; i++) begin wdq.push_back('0); wsq.push_back('1); end
    axi_write(64'h40, DEPTH - 5, 2'b01, 3'd4, DEPTH - 5, 1'b0, resp);
    check("fill_bresp", resp, 0);
    model_write(4, DEPTH - 5, 2'b01);

    // INCR write/read at 0x100
    wdq.delete(); wsq.delete();
    for (int i = 0; i < 4; i++) begin wdq.push_back(DW'(i + 1)); wsq.push_back('1); end
    axi_write(64'h100, 3, 2'b01, 3'd4, 3, 1'b0, resp);
    check("incr_bresp", resp, 0);
    model_write(16, 3, 2'b01);
    axi_read(64'h100, 3, 2'b01, 3'd4);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rdq[i], DW'(i + 1));
      check("incr_rresp", rrq[i], 0);
      check("incr_rlast", rlq[i], (i == 3));
    end

    // WRAP read starting mid-block
    axi_read(64'h130, 3, 2'b10, 3'd4);
    check("wrap_d0", rdq[0], 4); check("wrap_d1", rdq[1], 1);
    check("wrap_d2", rdq[2], 2); check("wrap_d3", rdq[3], 3);
    check("wrap_rresp", rrq[3], 0);

    // Byte strobes over a zeroed word
    wdq.delete(); wsq.delete();
    wdq.push_back('1); wsq.push_back(16'h000F);
    axi_write(64'h200, 0, 2'b01, 3'd4, 0, 1'b0, resp);
    model_write(32, 0, 2'b01);
    axi_read(64'h200, 0, 2'b01, 3'd4);
    check("strb_rdata", rdq[0], 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);

    // CSR and start/done handshake
    wr1(64'h00, 128'h1000, resp);
    wr1(64'h10, 128'h2000, resp);
    check("in_off", input_Addr_Offset, 64'h1000);
    check("out_off", output_Addr_Offset, 64'h2000);
    check("no_init_yet", init_cnt, 0);
    wr1(64'h20, 128'h1, resp);
    @(posedge clk); #1;
    check("init_once", init_cnt, 1);
    axi_read(64'h30, 0, 2'b01, 3'd4);
    check("status_busy", rdq[0], 1);
    axi_read(64'h20, 0, 2'b01, 3'd4);
    check("start_reads0", rdq[0], 0);
    wr1(64'h20, 128'h1, resp);
    @(posedge clk); #1;
    check("no_pulse_busy", init_cnt, 1);
    pulse(1'b1);
    axi_read(64'h30, 0, 2'b01, 3'd4);
    check("status_done", rdq[0], 2);
    wr1(64'h30, '1, resp);
    check("status_wr_okay", resp, 0);
    axi_read(64'h30, 0, 2'b01, 3'd4);
    check("status_ro", rdq[0], 2);
    wr1(64'h20, 128'h1, resp);
    @(posedge clk); #1;
    check("init_twice", init_cnt, 2);
    pulse(1'b0);
    axi_read(64'h30, 0, 2'b01, 3'd4);
    check("status_err", rdq[0], 5);
    pulse(1'b1);
    axi_read(64'h30, 0, 2'b01, 3'd4);
    check("status_done_err", rdq[0], 6);

    // Error responses
    wdq.delete(); wsq.delete();
    for (int i = 0; i < 2; i++) begin wdq.push_back({4{$urandom}}); wsq.push_back('1); end
    axi_write(64'h100, 1, 2'b11, 3'd4, 1, 1'b0, resp);
    check("bad_burst_bresp", resp, 2);
    axi_write(64'h100, 1, 2'b01, 3'd3, 1, 1'b0, resp);
    check("bad_size_bresp", resp, 2);
    axi_write(64'h100, 1, 2'b01, 3'd4, 0, 1'b0, resp);
    check("early_wlast_bresp", resp, 2);
    axi_write(64'h100, 0, 2'b01, 3'd4, -1, 1'b0, resp);
    check("late_wlast_bresp", resp, 2);
    axi_write(64'h100 | (64'h1 << 40), 0, 2'b01, 3'd4, 0, 1'b0, resp);
    check("oor_bresp", resp, 2);
    axi_read(64'h100, 1, 2'b01, 3'd4);
    check("err_unchanged0", rdq[0], model[16]);
    check("err_unchanged1", rdq[1], model[17]);
    axi_read(64'h1 << 40, 0, 2'b01, 3'd4);
    check("oor_rresp", rrq[0], 2);
    check("oor_rdata", rdq[0], 0);
    axi_read(64'h100, 2, 2'b10, 3'd4);
    for (int i = 0; i < 3; i++) begin
      check("badwrap_rresp", rrq[i], 2);
      check("badwrap_rdata", rdq[i], 0);
    end
    check("badwrap_rlast", rlq[2], 1);

    // Randomized bursts against the model
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        bt = 2'b00; len = $urandom_range(0, 3); start = $urandom_range(4, DEPTH - 1);
      end else if (kind == 1) begin
        bt = 2'b01; len = $urandom_range(0, 15); start = $urandom_range(8, DEPTH - 16);
      end else begin
        bt = 2'b10; len = (2 << $urandom_range(0, 3)) - 1; start = $urandom_range(16, DEPTH - 1);
      end
      wdq.delete(); wsq.delete();
      for (int i = 0; i <= len; i++) begin
        wdq.push_back({$urandom, $urandom, $urandom, $urandom});
        wsq.push_back(16'($urandom));
      end
      axi_write(AW'(start) << 4, len, bt, 3'd4, len, 1'b0, resp);
      check("rand_bresp", resp, 0);
      model_write(start, len, bt);
      axi_read(AW'(start) << 4, len, bt, 3'd4);
      for (int i = 0; i <= len; i++) begin
        check("rand_rdata", rdq[i], model[beat_idx(start, len, bt, i)]);
        check("rand_rresp", rrq[i], 0);
        check("rand_rlast", rlq[i], (i == len));
      end
    end

    // Reset in the middle of outstanding write response and read burst
    wdq.delete(); wsq.delete();
    wdq.push_back({4{$urandom}}); wsq.push_back('1);
    axi_write(64'h100, 0, 2'b01, 3'd4, 0, 1'b1, resp);
    model_write(16, 0, 2'b01);
    S_AXI_ARADDR = 64'h100; S_AXI_ARLEN = 8'd3; S_AXI_ARSIZE = 3'd4;
    S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1; S_AXI_ARVALID = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_rvalid", S_AXI_RVALID, 1);
    check("pre_rst_bvalid", S_AXI_BVALID, 1);
    check("hold_rdata", S_AXI_RDATA, model[16]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", S_AXI_RVALID, 0);
    check("mid_rst_bvalid", S_AXI_BVALID, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(64'h30, 0, 2'b01, 3'd4);
    check("post_rst_status", rdq[0], 0);
    check("post_rst_in_off", input_Addr_Offset, 0);
    axi_read(64'h100, 0, 2'b01, 3'd4);
    check("post_rst_mem", rdq[0], model[16]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi4_burst_csr_slave.md
Name: axi4_burst_csr_slave

Overview:
Parameterised AXI4 full slave fronting the accelerator. It holds a word-addressed register-backed buffer with a control/status register (CSR) window in words 0..3. It supports FIXED/INCR/WRAP bursts, byte strobes, per-burst error responses, and a start/busy/done/error handshake with the accelerator's AXI master. It sits between the PS interconnect and the feature-extractor master engine.

Parameters:
C_S_AXI_ID_WIDTH, 12, AXI ID width
C_S_AXI_DATA_WIDTH, 128, data width (32/64/128/256)
C_S_AXI_ADDR_WIDTH, 64, address width
C_MEM_DEPTH, 256, buffer depth in data words (power of 2, >=8); words 0..3 are CSR

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset; asynchronous assert, active-low
S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address channel
S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  AW handshake
S_AXI_WDATA/WSTRB/WLAST/WVALID  in  DATA/DATA/8/1/1  write data channel
S_AXI_WREADY  out  1  W handshake
S_AXI_BID/BRESP/BVALID  out  ID/2/1; S_AXI_BREADY in 1  write response
S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID/ADDR/8/3/2/1  read address
S_AXI_ARREADY  out  1  AR handshake
S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID/DATA/2/1/1; S_AXI_RREADY in 1  read data
input_Addr_Offset  out  ADDR  CSR word0[ADDR-1:0]
output_Addr_Offset  out  ADDR  CSR word1[ADDR-1:0]
INIT_AXI_TXN  out  1  one-cycle start pulse to master
TXN_DONE  in  1  master completion pulse
ERROR  in  1  master error indication

Behaviour:
- Reset: all valids/readies 0, BRESP/RRESP 0, RLAST 0, FSMs idle, CSR words 0..2 = 0, status flags 0, INIT_AXI_TXN 0. Buffer words >=4 are not reset. Reset mid-burst abandons the burst; no response is issued.
- Word index = addr[LSB+log2(DEPTH)-1 : LSB], where LSB = log2(DATA/8). Any nonzero address bit above the index flags the burst out-of-range.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - AWREADY=1 only in W_IDLE. Handshake latches ID, address, len, size, burst.
  - W_DATA: WREADY=1. Each beat writes bytes whose WSTRB bit is set, then advances the address.
  - Beat count (AWLEN+1) ends the burst, not WLAST. WLAST early or late flags SLVERR.
  - W_RESP: BVALID=1, BID=latched ID; held until BREADY. Next AWREADY the cycle after the B handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - ARREADY=1 only in R_IDLE.
  - RVALID asserts the cycle after the AR handshake. Beats stream back-to-back while RREADY=1; RDATA/RLAST are held while RREADY=0.
  - RLAST=1 on beat ARLEN. Return to R_IDLE after the last handshake.
- Address advance:
  - FIXED: constant.
  - INCR: +1 word, modulo C_MEM_DEPTH.
  - WRAP: legal len 1/3/7/15, wraps within the aligned (len+1)-word block.
- SLVERR (2'b10) for any of: burst=2'b11; WRAP with illegal len; size != LSB; out-of-range address; WLAST mismatch.
  - An errored write commits no beats. It still consumes all AWLEN+1 beats.
  - An errored read returns zero data with SLVERR on every beat.
- Read and write channels are independent. A same-word read and write in one cycle returns the old data.
- CSR:
  - word0/word1: R/W.
  - word2 bit0 START: write-1 with WSTRB[0]=1 while not busy gives INIT_AXI_TXN=1 for exactly the next cycle, sets busy, and clears done/error. Ignored while busy. Reads as 0.
  - word3 STATUS (read-only, writes ignored with OKAY): bit0 busy, bit1 done (sticky), bit2 error (sticky).
  - TXN_DONE clears busy and sets done.
  - ERROR while busy sets error.
  - TXN_DONE and START in the same cycle: done wins; the START is ignored.

Test Plan:
- INCR write AWADDR=0x100, AWLEN=3, 128-bit, WSTRB all-ones, data 1..4, then INCR read -> BRESP=00; RDATA 1,2,3,4; RLAST only on beat 3.
- WRAP read ARADDR=0x130, ARLEN=3 -> word order 3,0,1,2 of block 0x100; RRESP=00.
- Write word 0x200 with WSTRB=0x000F, data all 0xFF over prior all-0x00 -> readback bytes 0..3 = 0xFF, rest 0x00.
- Write 0x1000 to word0, 0x2000 to word1, then START=1 -> input_Addr_Offset=0x1000, output_Addr_Offset=0x2000; INIT_AXI_TXN one pulse; STATUS=0x1. Second START while busy -> no pulse. TXN_DONE -> STATUS=0x2.
- AWBURST=2'b11 AWLEN=1 to 0x100; out-of-range ARADDR=1<<40 -> BRESP=10 and word unchanged; RRESP=10 with RDATA=0.
- Assert ARESETN low mid-4-beat read with RREADY=0 -> RVALID=0 and BVALID=0 immediately; STATUS=0 after release.
